// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the ALU issue sequencer: FSM states and
// separator-word construction.
package alu_seq_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SEP, S_EXEC} seq_state_t;

  localparam logic [3:0] OPC_LDI = 4'hF;

  // Load-immediate of n into the scratch register.
  function automatic logic [15:0] sep_word(input logic [3:0] scratch, input logic n);
    return {OPC_LDI, scratch, 7'b0, n};
  endfunction

  // Toggle away from a previous separator so the bus always changes; otherwise SEP0.
  function automatic logic [15:0] next_sep(input logic [15:0] last, input logic [3:0] scratch);
    logic [15:0] s0;
    s0 = sep_word(scratch, 1'b0);
    if (last[15:1] == s0[15:1]) return sep_word(scratch, ~last[0]);
    return s0;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Valid/ready instruction channel from the producer into the sequencer.
interface alu_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;

  modport master (output in_valid, output in_instr, input  in_ready);
  modport slave  (input  in_valid, input  in_instr, output in_ready);
endinterface

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO; full/empty derived from pointers carrying one extra wrap bit.
module alu_seq_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i && !empty_o) rd_q <= rd_q + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/alu_sequencer.sv
// Issue controller: buffers instructions and holds each on the ALU bus for a settle
// window, inserting a scratch-register separator whenever a word would repeat.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int SCRATCH_REG   = 15
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  in_if,
  input  logic            halt,
  input  logic            step,
  output logic [15:0]     alu_instr,
  output logic            busy,
  output logic            retire,
  output logic [15:0]     retired_count,
  output logic [7:0]      sep_count
);
  localparam logic [3:0]  SCR      = 4'(SCRATCH_REG);
  localparam logic [15:0] SEP0     = sep_word(SCR, 1'b0);
  localparam int          CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

  seq_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] pend_q, pend_d, last_q, last_d, alu_q, alu_d, ret_q, ret_d;
  logic [7:0]  sep_q, sep_d;
  logic        push, pop, full, empty;
  logic [15:0] head;

  assign in_if.in_ready = !full;
  assign push           = in_if.in_valid && in_if.in_ready;

  alu_seq_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_if.in_instr),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    last_d  = last_q;
    alu_d   = alu_q;
    ret_d   = ret_q;
    sep_d   = sep_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty && (!halt || step)) begin
          pop    = 1'b1;
          pend_d = head;
          cnt_d  = CNT_INIT;
          if (head == last_q) begin
            state_d = S_SEP;
            alu_d   = next_sep(last_q, SCR);
          end else begin
            state_d = S_EXEC;
            alu_d   = head;
          end
        end
      end
      S_SEP: begin
        if (cnt_q == '0) begin
          if (sep_q != 8'hFF) sep_d = sep_q + 8'd1;
          last_d  = alu_q;
          alu_d   = pend_q;
          cnt_d   = CNT_INIT;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          ret_d   = ret_q + 16'd1;
          last_d  = pend_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      last_q  <= SEP0;
      alu_q   <= SEP0;
      ret_q   <= '0;
      sep_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      alu_q   <= alu_d;
      ret_q   <= ret_d;
      sep_q   <= sep_d;
    end
  end

  assign alu_instr     = alu_q;
  assign busy          = (state_q != S_IDLE) || !empty;
  assign retire        = (state_q == S_EXEC) && (cnt_q == '0);
  assign retired_count = ret_q;
  assign sep_count     = sep_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed timing sequences, a vector table and a randomized
// run checked against a transaction-level model of the issued bus words.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst, halt, step;
  logic [15:0] alu_instr, retired_count;
  logic        busy, retire;
  logic [7:0]  sep_count;

  alu_sequencer_if bus();

  alu_sequencer #(.DEPTH(4), .SETTLE_CYCLES(2), .SCRATCH_REG(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_if         (bus.slave),
    .halt          (halt),
    .step          (step),
    .alu_instr     (alu_instr),
    .busy          (busy),
    .retire        (retire),
    .retired_count (retired_count),
    .sep_count     (sep_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed bus words (one entry per bus change), retire pulses, accepted words.
  logic [15:0] trace[$];
  logic [15:0] acc[$];
  int          n_ret;
  logic [15:0] prev;

  always @(negedge clk) begin
    if (rst) begin
      trace.delete();
      acc.delete();
      n_ret = 0;
      prev  = 16'hFF00;
    end else begin
      if (alu_instr !== prev) begin
        trace.push_back(alu_instr);
        prev = alu_instr;
      end
      if (retire) n_ret++;
      if (bus.in_valid && bus.in_ready) acc.push_back(bus.in_instr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_instr = '0; halt = 1'b0; step = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic push(input logic [15:0] w);
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    cyc(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cyc(1);
    step = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 200) begin
      cyc(1);
      k++;
    end
    check({name, "_idle_timeout"}, busy, 1'b0);
  endtask

  typedef struct {
    logic [15:0] w0, w1;
    int          n;
    logic [15:0] e0, e1, e2;
    logic [7:0]  seps;
  } vec_t;

  vec_t        vt[5];
  logic [15:0] pool[6] = '{16'h1230, 16'hFF00, 16'hFF01, 16'h0F0F, 16'h1230, 16'hABCD};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Each vector starts from reset (last = FF00); e0..e2 is the expected bus order.
    vt[0] = '{16'h1230, 16'h2451, 2, 16'h1230, 16'h2451, 16'h0000, 8'd0};
    vt[1] = '{16'h1230, 16'h1230, 3, 16'h1230, 16'hFF00, 16'h1230, 8'd1};
    vt[2] = '{16'hFF00, 16'h1234, 3, 16'hFF01, 16'hFF00, 16'h1234, 8'd1};
    vt[3] = '{16'hFF01, 16'hFF01, 3, 16'hFF01, 16'hFF00, 16'hFF01, 8'd1};
    vt[4] = '{16'h0000, 16'hFF00, 2, 16'h0000, 16'hFF00, 16'h0000, 8'd0};

    // Reset state
    do_reset();
    check("rst_alu", alu_instr, 16'hFF00);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_retire", retire, 1'b0);
    check("rst_retired", retired_count, 16'd0);
    check("rst_sep", sep_count, 8'd0);

    // Issue timing of two distinct words
    do_reset();
    push(16'h1230);
    push(16'h2451);
    check("t2_issue0", alu_instr, 16'h1230);
    check("t2_retire0", retire, 1'b0);
    cyc(1);
    check("t2_hold1", alu_instr, 16'h1230);
    check("t2_retire1", retire, 1'b1);
    cyc(1);
    check("t2_idle_gap", alu_instr, 16'h1230);
    check("t2_idle_retire", retire, 1'b0);
    cyc(1);
    check("t2_issue1", alu_instr, 16'h2451);
    wait_idle("t2");
    check("t2_retired", retired_count, 16'd2);
    check("t2_pulses", n_ret, 2);
    check("t2_sep", sep_count, 8'd0);

    // Vector table: two pushes, bus order and counters
    for (int v = 0; v < 5; v++) begin
      logic [15:0] ex[3];
      do_reset();
      push(vt[v].w0);
      push(vt[v].w1);
      wait_idle($sformatf("vec%0d", v));
      ex = '{vt[v].e0, vt[v].e1, vt[v].e2};
      check($sformatf("vec%0d_len", v), trace.size(), vt[v].n);
      for (int i = 0; i < vt[v].n; i++)
        if (i < trace.size()) check($sformatf("vec%0d_bus%0d", v, i), trace[i], ex[i]);
      check($sformatf("vec%0d_sep", v), sep_count, vt[v].seps);
      check($sformatf("vec%0d_retired", v), retired_count, 16'd2);
    end

    // Halt with full FIFO, single steps, step dropped outside IDLE
    do_reset();
    halt = 1'b1;
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    check("t5_ready3", bus.in_ready, 1'b1);
    push(16'h4444);
    check("t5_full", bus.in_ready, 1'b0);
    cyc(3);
    check("t5_halted_bus", alu_instr, 16'hFF00);
    pulse_step();
    check("t5_step1", alu_instr, 16'h1111);
    check("t5_ready_after_pop", bus.in_ready, 1'b1);
    pulse_step();
    cyc(3);
    check("t5_step_dropped", alu_instr, 16'h1111);
    check("t5_ret1", retired_count, 16'd1);
    pulse_step();
    check("t5_step2", alu_instr, 16'h2222);
    cyc(4);
    pulse_step();
    check("t5_step3", alu_instr, 16'h3333);
    cyc(4);
    check("t5_ret3", retired_count, 16'd3);
    check("t5_busy_left", busy, 1'b1);
    check("t5_bus_hold", alu_instr, 16'h3333);
    halt = 1'b0;
    wait_idle("t5");
    check("t5_ret4", retired_count, 16'd4);
    check("t5_last", alu_instr, 16'h4444);

    // Reset in the middle of EXEC
    do_reset();
    push(16'h3450);
    cyc(1);
    check("t6_exec", alu_instr, 16'h3450);
    check("t6_no_retire_yet", retire, 1'b0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t6_alu", alu_instr, 16'hFF00);
    check("t6_busy", busy, 1'b0);
    check("t6_retire", retire, 1'b0);
    check("t6_ready", bus.in_ready, 1'b1);
    cyc(3);
    check("t6_retired", retired_count, 16'd0);
    check("t6_pulses", n_ret, 0);
    check("t6_bus_still", alu_instr, 16'hFF00);

    // Randomized traffic with halt/step against the bus-order model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_instr = pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      step = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    bus.in_valid = 1'b0;
    halt = 1'b0;
    step = 1'b0;
    cyc(1);
    wait_idle("rnd");
    begin
      logic [15:0] last, sep;
      logic [15:0] exp_q[$];
      int          es;
      last = 16'hFF00;
      es   = 0;
      foreach (acc[i]) begin
        if (acc[i] == last) begin
          sep = (last[15:1] == 15'h7F80) ? {last[15:1], ~last[0]} : 16'hFF00;
          exp_q.push_back(sep);
          es++;
          last = sep;
        end
        exp_q.push_back(acc[i]);
        last = acc[i];
      end
      check("rnd_len", trace.size(), exp_q.size());
      foreach (exp_q[i])
        if (i < trace.size()) check($sformatf("rnd_bus%0d", i), trace[i], exp_q[i]);
      check("rnd_retired", retired_count, 16'(acc.size()));
      check("rnd_pulses", n_ret, acc.size());
      check("rnd_sep", sep_count, 8'(es));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
